// File: rtl/envm_detection_ctrl_if.sv
// Handshake bundle between the self-test sweep controller, the BIST/compare
// engine, the eNVM fault-storage write port and the repair/remap logic.
interface envm_detection_ctrl_if #(
   parameter int SYSTOLIC_SIZE = 8,
   parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
);
   logic                     start;
   logic                     test_req;
   logic [ADDR_WIDTH-1:0]    test_row;
   logic                     test_done;
   logic [SYSTOLIC_SIZE-1:0] pe_result;
   logic                     row_result;
   logic                     col_result;
   logic                     detection_en;
   logic [ADDR_WIDTH-1:0]    count;
   logic [SYSTOLIC_SIZE-1:0] pe_detection;
   logic                     row_fault_detection;
   logic                     column_fault_detection;
   logic                     busy;
   logic                     done;
   logic                     fault_found;
   logic [ADDR_WIDTH:0]      faulty_row_count;
   logic                     timeout_err;

   modport master (
      input  start, test_done, pe_result, row_result, col_result,
      output test_req, test_row, detection_en, count, pe_detection,
             row_fault_detection, column_fault_detection, busy, done,
             fault_found, faulty_row_count, timeout_err
   );

   modport slave (
      output start, test_done, pe_result, row_result, col_result,
      input  test_req, test_row, detection_en, count, pe_detection,
             row_fault_detection, column_fault_detection, busy, done,
             fault_found, faulty_row_count, timeout_err
   );
endinterface

// File: rtl/envm_detection_ctrl.sv
// Array self-test sweep controller: requests a BIST per row, captures its fault
// flags, commits them to eNVM fault storage and guards each row with a watchdog.
module envm_detection_ctrl #(
   parameter int SYSTOLIC_SIZE  = 8,
   parameter int ADDR_WIDTH     = $clog2(SYSTOLIC_SIZE),
   parameter int TIMEOUT_CYCLES = 64,
   parameter int TO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1)
) (
   input logic               clk,
   input logic               rst,
   envm_detection_ctrl_if.master bus
);
   localparam int CNT_WIDTH = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);
   localparam logic [TO_WIDTH-1:0]   WD_LIMIT = TO_WIDTH'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t                   state_r, state_s;
   logic [ADDR_WIDTH-1:0]    idx_r, idx_s;
   logic [TO_WIDTH-1:0]      wd_r, wd_s;
   logic [ADDR_WIDTH-1:0]    test_row_r, test_row_s;
   logic [ADDR_WIDTH-1:0]    count_r, count_s;
   logic [SYSTOLIC_SIZE-1:0] pe_det_r, pe_det_s;
   logic                     row_det_r, row_det_s;
   logic                     col_det_r, col_det_s;
   logic                     fault_found_r, fault_found_s;
   logic [CNT_WIDTH-1:0]     faulty_cnt_r, faulty_cnt_s;
   logic                     timeout_err_r, timeout_err_s;
   logic                     test_req_r, test_req_s;
   logic                     det_en_r, det_en_s;
   logic                     busy_r, busy_s;
   logic                     done_r, done_s;

   function automatic logic any_flag(input logic [SYSTOLIC_SIZE-1:0] pe,
                                     input logic row, input logic col);
      return (|pe) | row | col;
   endfunction

   // Next-state, datapath and registered-output decode for the sweep FSM.
   always_comb begin
      state_s       = state_r;
      idx_s         = idx_r;
      wd_s          = wd_r;
      test_row_s    = test_row_r;
      count_s       = count_r;
      pe_det_s      = pe_det_r;
      row_det_s     = row_det_r;
      col_det_s     = col_det_r;
      fault_found_s = fault_found_r;
      faulty_cnt_s  = faulty_cnt_r;
      timeout_err_s = timeout_err_r;

      case (state_r)
         IDLE: begin
            if (bus.start) begin
               idx_s         = '0;
               test_row_s    = '0;
               fault_found_s = 1'b0;
               faulty_cnt_s  = '0;
               timeout_err_s = 1'b0;
               state_s       = REQ;
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            wd_s    = '0;
            state_s = WAIT;
         end
         WAIT: begin
            wd_s = wd_r + TO_WIDTH'(1);
            // A result arriving on the watchdog's last cycle still counts as a response.
            if (bus.test_done) begin
               pe_det_s  = bus.pe_result;
               row_det_s = bus.row_result;
               col_det_s = bus.col_result;
               count_s   = idx_r;
               state_s   = WRITE;
            end else if (wd_r == WD_LIMIT) begin
               pe_det_s      = '1;
               row_det_s     = 1'b1;
               col_det_s     = 1'b1;
               count_s       = idx_r;
               timeout_err_s = 1'b1;
               state_s       = WRITE;
            end else begin
               state_s = WAIT;
            end
         end
         WRITE: begin
            if (any_flag(pe_det_r, row_det_r, col_det_r)) begin
               fault_found_s = 1'b1;
               faulty_cnt_s  = faulty_cnt_r + CNT_WIDTH'(1);
            end else begin
               faulty_cnt_s  = faulty_cnt_r;
            end
            if (idx_r == LAST_ROW) begin
               state_s = DONE;
            end else begin
               idx_s      = idx_r + ADDR_WIDTH'(1);
               test_row_s = idx_r + ADDR_WIDTH'(1);
               state_s    = REQ;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      test_req_s = (state_s == REQ);
      det_en_s   = (state_s == WRITE);
      busy_s     = (state_s != IDLE);
      done_s     = (state_s == DONE);
   end

   // State, datapath and output registers; reset drops everything to zero at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= IDLE;
         idx_r         <= '0;
         wd_r          <= '0;
         test_row_r    <= '0;
         count_r       <= '0;
         pe_det_r      <= '0;
         row_det_r     <= 1'b0;
         col_det_r     <= 1'b0;
         fault_found_r <= 1'b0;
         faulty_cnt_r  <= '0;
         timeout_err_r <= 1'b0;
         test_req_r    <= 1'b0;
         det_en_r      <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
      end else begin
         state_r       <= state_s;
         idx_r         <= idx_s;
         wd_r          <= wd_s;
         test_row_r    <= test_row_s;
         count_r       <= count_s;
         pe_det_r      <= pe_det_s;
         row_det_r     <= row_det_s;
         col_det_r     <= col_det_s;
         fault_found_r <= fault_found_s;
         faulty_cnt_r  <= faulty_cnt_s;
         timeout_err_r <= timeout_err_s;
         test_req_r    <= test_req_s;
         det_en_r      <= det_en_s;
         busy_r        <= busy_s;
         done_r        <= done_s;
      end
   end

   assign bus.test_req               = test_req_r;
   assign bus.test_row               = test_row_r;
   assign bus.detection_en           = det_en_r;
   assign bus.count                  = count_r;
   assign bus.pe_detection           = pe_det_r;
   assign bus.row_fault_detection    = row_det_r;
   assign bus.column_fault_detection = col_det_r;
   assign bus.busy                   = busy_r;
   assign bus.done                   = done_r;
   assign bus.fault_found            = fault_found_r;
   assign bus.faulty_row_count       = faulty_cnt_r;
   assign bus.timeout_err            = timeout_err_r;
endmodule

// File: tb/tb_envm_detection_ctrl.sv
// Self-checking bench for envm_detection_ctrl: table-driven and randomized
// sweeps against a per-row behavioural model, plus reset/spurious-input corners.
module tb_envm_detection_ctrl;
   localparam int SZ = 8;
   localparam int TO = 64;
   localparam int LIMIT = SZ * (TO + 2) + 20;

   typedef struct {
      int         delay;   // WAIT cycle on which test_done is driven; 0 = never
      logic       spur;    // also pulse test_done (garbage) during REQ
      logic [7:0] pe;
      logic       r;
      logic       c;
      logic [7:0] exp_pe;
      logic       exp_r;
      logic       exp_c;
      logic       exp_to;
   } row_vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   envm_detection_ctrl_if #(.SYSTOLIC_SIZE(SZ)) bus ();

   envm_detection_ctrl #(.SYSTOLIC_SIZE(SZ), .TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   int         cfg_delay [SZ];
   logic       cfg_spur  [SZ];
   logic [7:0] cfg_pe    [SZ];
   logic       cfg_r     [SZ];
   logic       cfg_c     [SZ];
   logic [7:0] exp_pe    [SZ];
   logic       exp_r     [SZ];
   logic       exp_c     [SZ];
   logic       exp_to    [SZ];

   row_vec_t vec [SZ];

   int req_cnt = 0;
   int wr_cnt  = 0;
   bit spur_done = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   // Behavioural model: a row answered within the watchdog window keeps its
   // flags; otherwise it is recorded as fully faulty and flagged as timed out.
   task automatic model_expect();
      for (int i = 0; i < SZ; i++) begin
         if (cfg_delay[i] >= 1 && cfg_delay[i] <= TO) begin
            exp_pe[i] = cfg_pe[i];
            exp_r[i]  = cfg_r[i];
            exp_c[i]  = cfg_c[i];
            exp_to[i] = 1'b0;
         end else begin
            exp_pe[i] = 8'hFF;
            exp_r[i]  = 1'b1;
            exp_c[i]  = 1'b1;
            exp_to[i] = 1'b1;
         end
      end
   endtask

   // BIST engine stand-in: answers each test_req after the configured delay.
   int  wcnt = 0;
   int  cur = 0;
   bit  active = 1'b0;
   always @(negedge clk) begin
      bus.test_done = spur_done;
      if (rst) begin
         active         = 1'b0;
         bus.pe_result  = 8'h00;
         bus.row_result = 1'b0;
         bus.col_result = 1'b0;
      end else if (bus.test_req) begin
         cur    = int'(bus.test_row);
         wcnt   = 0;
         active = 1'b1;
         if (cfg_spur[cur]) begin
            bus.test_done  = 1'b1;
            bus.pe_result  = 8'hA5;
            bus.row_result = 1'b1;
            bus.col_result = 1'b1;
         end
      end else if (active) begin
         wcnt++;
         if (wcnt == cfg_delay[cur]) begin
            bus.test_done  = 1'b1;
            bus.pe_result  = cfg_pe[cur];
            bus.row_result = cfg_r[cur];
            bus.col_result = cfg_c[cur];
            active         = 1'b0;
         end
      end
   end

   // Monitor: every request and every eNVM write must follow row order and the model.
   always @(negedge clk) begin
      if (bus.test_req) begin
         chk("req_row", 32'(bus.test_row), req_cnt);
         req_cnt++;
      end
      if (bus.detection_en) begin
         if (wr_cnt < SZ) begin
            chk("wr_count", 32'(bus.count), wr_cnt);
            chk("wr_test_row", 32'(bus.test_row), wr_cnt);
            chk("wr_pe", 32'(bus.pe_detection), 32'(exp_pe[wr_cnt]));
            chk("wr_row_flag", 32'(bus.row_fault_detection), 32'(exp_r[wr_cnt]));
            chk("wr_col_flag", 32'(bus.column_fault_detection), 32'(exp_c[wr_cnt]));
         end else begin
            chk("extra_write", wr_cnt, SZ - 1);
         end
         wr_cnt++;
      end
   end

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, 32'(bus.busy), 0);
      chk({tag, "_done"}, 32'(bus.done), 0);
      chk({tag, "_test_req"}, 32'(bus.test_req), 0);
      chk({tag, "_test_row"}, 32'(bus.test_row), 0);
      chk({tag, "_det_en"}, 32'(bus.detection_en), 0);
      chk({tag, "_count"}, 32'(bus.count), 0);
      chk({tag, "_pe_det"}, 32'(bus.pe_detection), 0);
      chk({tag, "_row_det"}, 32'(bus.row_fault_detection), 0);
      chk({tag, "_col_det"}, 32'(bus.column_fault_detection), 0);
      chk({tag, "_fault_found"}, 32'(bus.fault_found), 0);
      chk({tag, "_faulty_cnt"}, 32'(bus.faulty_row_count), 0);
      chk({tag, "_timeout_err"}, 32'(bus.timeout_err), 0);
   endtask

   // One complete sweep from IDLE, checked against the expected arrays.
   task automatic run_sweep(input bit poke);
      int   cyc;
      int   exp_cyc;
      int   exp_frc;
      bit   seen;
      logic exp_ff;
      logic exp_to_any;
      exp_cyc    = 2;
      exp_frc    = 0;
      exp_ff     = 1'b0;
      exp_to_any = 1'b0;
      for (int i = 0; i < SZ; i++) begin
         exp_cyc += ((cfg_delay[i] >= 1 && cfg_delay[i] <= TO) ? cfg_delay[i] : TO) + 2;
         if (exp_pe[i] != 8'h00 || exp_r[i] || exp_c[i]) begin
            exp_frc++;
            exp_ff = 1'b1;
         end
         if (exp_to[i]) exp_to_any = 1'b1;
      end
      req_cnt   = 0;
      wr_cnt    = 0;
      seen      = 1'b0;
      cyc       = 0;
      bus.start = 1'b1;
      while (!seen && cyc < LIMIT) begin
         @(negedge clk);
         cyc++;
         bus.start = (poke && cyc == 2);   // lands in WAIT of row 0: must be ignored
         if (bus.done) seen = 1'b1;
      end
      chk("done_seen", 32'(seen), 1);
      chk("sweep_cycles", cyc + 1, exp_cyc);
      chk("req_total", req_cnt, SZ);
      chk("write_total", wr_cnt, SZ);
      chk("fault_found", 32'(bus.fault_found), 32'(exp_ff));
      chk("faulty_row_count", 32'(bus.faulty_row_count), exp_frc);
      chk("timeout_err", 32'(bus.timeout_err), 32'(exp_to_any));
      bus.start = poke;                    // coincident with DONE: ignored
      @(negedge clk);
      bus.start = 1'b0;
      chk("done_single_pulse", 32'(bus.done), 0);
      chk("idle_after_done", 32'(bus.busy), 0);
      @(negedge clk);
      @(negedge clk);
      chk("still_idle", 32'(bus.busy), 0);
      chk("ff_hold", 32'(bus.fault_found), 32'(exp_ff));
      chk("frc_hold", 32'(bus.faulty_row_count), exp_frc);
      chk("to_hold", 32'(bus.timeout_err), 32'(exp_to_any));
   endtask

   initial begin
      int n;
      bus.start = 1'b0;
      for (int i = 0; i < SZ; i++) begin
         cfg_delay[i] = 1; cfg_spur[i] = 1'b0; cfg_pe[i] = 8'h00;
         cfg_r[i] = 1'b0;  cfg_c[i] = 1'b0;
      end
      model_expect();

      // Directed row table: clean, row flag, PE flag, no answer, coincident
      // answer at the watchdog limit, column flag, answer too late, spurious REQ.
      vec[0] = '{1,  1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      vec[1] = '{3,  1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
      vec[2] = '{1,  1'b0, 8'h10, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
      vec[3] = '{0,  1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1};
      vec[4] = '{64, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      vec[5] = '{2,  1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
      vec[6] = '{65, 1'b0, 8'h3C, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1};
      vec[7] = '{1,  1'b1, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0};

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // All rows clean, with a stray start in WAIT and one coincident with DONE.
      run_sweep(1'b1);

      // test_done while idle must not start anything.
      spur_done = 1'b1;
      repeat (4) @(negedge clk);
      spur_done = 1'b0;
      chk("idle_spurious_busy", 32'(bus.busy), 0);
      @(negedge clk);

      // Table-driven sweep.
      for (int i = 0; i < SZ; i++) begin
         cfg_delay[i] = vec[i].delay; cfg_spur[i] = vec[i].spur;
         cfg_pe[i] = vec[i].pe; cfg_r[i] = vec[i].r; cfg_c[i] = vec[i].c;
         exp_pe[i] = vec[i].exp_pe; exp_r[i] = vec[i].exp_r;
         exp_c[i] = vec[i].exp_c; exp_to[i] = vec[i].exp_to;
      end
      run_sweep(1'b0);

      // Randomized sweeps against the model.
      for (int s = 0; s < 6; s++) begin
         for (int i = 0; i < SZ; i++) begin
            n = $urandom_range(0, 9);
            cfg_delay[i] = (n == 0) ? 0 : (n == 1) ? $urandom_range(60, 66) : $urandom_range(1, 6);
            cfg_pe[i]   = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            cfg_r[i]    = ($urandom_range(0, 3) == 0);
            cfg_c[i]    = ($urandom_range(0, 3) == 0);
            cfg_spur[i] = ($urandom_range(0, 3) == 0);
         end
         model_expect();
         run_sweep(s == 1);
      end

      // Reset during WAIT of row 4, then a fresh sweep from row 0.
      for (int i = 0; i < SZ; i++) begin
         cfg_delay[i] = 3; cfg_spur[i] = 1'b0; cfg_pe[i] = 8'(8'h01 << i);
         cfg_r[i] = 1'b0;  cfg_c[i] = 1'b0;
      end
      model_expect();
      req_cnt = 0;
      wr_cnt  = 0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n = 0;
      while (!(bus.test_req && bus.test_row == 3'd4) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("row4_req_seen", 32'(bus.test_req && bus.test_row == 3'd4), 1);
      @(negedge clk);
      chk("row4_wait_busy", 32'(bus.busy), 1);
      chk("ff_before_rst", 32'(bus.fault_found), 1);
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_writes", wr_cnt, 4);
      for (int i = 0; i < SZ; i++) begin
         cfg_delay[i] = 1 + (i % 3); cfg_pe[i] = (i == 6) ? 8'h02 : 8'h00;
      end
      model_expect();
      run_sweep(1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
